// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the next-PC logic.
//   EXC_VECTOR / IRQ_VECTOR : redirect entry addresses
//   PC_STEP                 : sequential fetch increment
//   btb_ctr_e               : 2-bit saturating branch-direction counter states
//   ctr_step()              : counter next state for one resolved branch outcome
package pipeline_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;
  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
  localparam logic [31:0] PC_STEP    = 32'd4;

  typedef enum logic [1:0] {
    SNT = 2'd0,  // strongly not taken
    WNT = 2'd1,  // weakly not taken (reset state)
    WT  = 2'd2,  // weakly taken (state on allocation)
    ST  = 2'd3   // strongly taken
  } btb_ctr_e;

  // Saturating step: taken moves toward ST, not taken toward SNT.
  function automatic btb_ctr_e ctr_step(input btb_ctr_e cur, input logic taken);
    btb_ctr_e nxt;
    nxt = cur;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = WNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   lookup_pc_i           : fetch PC to predict for (combinational lookup)
//   pred_taken_o          : hit and counter in a taken state
//   pred_target_o         : stored target of the looked-up entry
//   upd_en_i              : apply a resolved branch at the next clock edge
//   upd_pc_i              : PC of the resolved branch (selects entry and tag)
//   upd_taken_i           : actual branch outcome
//   upd_target_i          : actual taken target
// A lookup and an update of the same index in one cycle see the pre-edge
// contents; the write lands on the clock edge.
module branch_target_buffer
  import pipeline_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lookup_pc_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_en_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
);

  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  btb_ctr_e         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;

  logic             wr_en_d;
  btb_ctr_e         ctr_d;
  logic [31:0]      target_d;

  // Byte-offset bits of a word-aligned PC carry no information here.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  assign lk_idx  = lookup_pc_i[IDX_W+1:2];
  assign lk_tag  = lookup_pc_i[31:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[31:IDX_W+2];

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Prediction: taken only on a tag hit with the counter's upper bit set.
  assign pred_taken_o  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag)
                         && ((ctr_q[lk_idx] == WT) || (ctr_q[lk_idx] == ST));
  assign pred_target_o = target_q[lk_idx];

  // Next contents of the entry selected by the update port.
  always_comb begin
    wr_en_d  = 1'b0;
    ctr_d    = ctr_q[upd_idx];
    target_d = target_q[upd_idx];
    if (upd_en_i) begin
      if (upd_hit) begin
        wr_en_d = 1'b1;
        ctr_d   = ctr_step(ctr_q[upd_idx], upd_taken_i);
        if (upd_taken_i) begin
          target_d = upd_target_i;
        end else begin
          target_d = target_q[upd_idx];
        end
      end else if (upd_taken_i) begin
        // Miss on a taken branch: claim the slot regardless of its owner.
        wr_en_d  = 1'b1;
        ctr_d    = WT;
        target_d = upd_target_i;
      end else begin
        wr_en_d = 1'b0;
      end
    end else begin
      wr_en_d = 1'b0;
    end
  end

  // Entry storage; reset clears every entry to invalid / weakly not taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= WNT;
      end
    end else if (wr_en_d) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= target_d;
      ctr_q[upd_idx]    <= ctr_d;
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC selection in front of the PC register.
// Ports:
//   clk, reset                         : clock, asynchronous active-high reset
//   pc_if                              : current fetch PC
//   hold_i                             : stall request from the hazard unit
//   id_jump_*, id_pred_*               : jump resolved in ID and its prediction
//   ex_br_valid, ex_pc, ex_taken,
//   ex_target, ex_pred_*               : conditional branch resolved in EX
//   exc_req, irq_req                   : exception / interrupt redirects
//   pc_next                            : next value for the PC register
//   pc_hold_o                          : PC register hold, dropped on any redirect
//   pred_taken, pred_target            : IF-stage BTB prediction
//   flush_if_id, flush_id_ex           : pipeline register flushes
//   mispredict_cnt                     : saturating count of EX mispredicts
// Priority: exception > interrupt > EX mispredict > ID jump > prediction > PC+4.
module next_pc_unit #(
  parameter int          ENTRIES    = 16,
  parameter int          IDX_W      = $clog2(ENTRIES),
  parameter logic [31:0] EXC_VECTOR = pipeline_pkg::EXC_VECTOR,
  parameter logic [31:0] IRQ_VECTOR = pipeline_pkg::IRQ_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_if,
  input  logic        hold_i,
  input  logic        id_jump_valid,
  input  logic [31:0] id_jump_target,
  input  logic        id_pred_taken,
  input  logic [31:0] id_pred_target,
  input  logic        ex_br_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic        exc_req,
  input  logic        irq_req,
  output logic [31:0] pc_next,
  output logic        pc_hold_o,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [31:0] mispredict_cnt
);

  logic        ex_mis;
  logic        id_redir;
  logic        redirect;
  logic [31:0] ex_redir_addr;
  logic [31:0] mis_cnt_q;
  logic [31:0] mis_cnt_d;

  branch_target_buffer #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_btb (
    .clk           (clk),
    .reset         (reset),
    .lookup_pc_i   (pc_if),
    .pred_taken_o  (pred_taken),
    .pred_target_o (pred_target),
    .upd_en_i      (ex_br_valid & ~exc_req),
    .upd_pc_i      (ex_pc),
    .upd_taken_i   (ex_taken),
    .upd_target_i  (ex_target)
  );

  // Wrong direction, or right direction (taken) to the wrong target.
  assign ex_mis = ex_br_valid &
                  ((ex_taken != ex_pred_taken) |
                   (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)));

  assign ex_redir_addr = ex_taken ? ex_target : (ex_pc + pipeline_pkg::PC_STEP);

  // A jump needs no redirect only when IF already fetched from its target.
  assign id_redir = id_jump_valid &
                    ~(id_pred_taken & (id_pred_target == id_jump_target));

  assign redirect    = exc_req | irq_req | ex_mis | id_redir;
  assign pc_hold_o   = hold_i & ~redirect;
  assign flush_id_ex = exc_req | irq_req | ex_mis;
  assign flush_if_id = flush_id_ex | id_redir;

  // Redirect arbitration, highest priority first.
  always_comb begin
    pc_next = pc_if + pipeline_pkg::PC_STEP;
    if (exc_req) begin
      pc_next = EXC_VECTOR;
    end else if (irq_req) begin
      pc_next = IRQ_VECTOR;
    end else if (ex_mis) begin
      pc_next = ex_redir_addr;
    end else if (id_redir) begin
      pc_next = id_jump_target;
    end else if (pred_taken) begin
      pc_next = pred_target;
    end else begin
      pc_next = pc_if + pipeline_pkg::PC_STEP;
    end
  end

  // Mispredict counter next value; an exception squashes the EX branch.
  always_comb begin
    mis_cnt_d = mis_cnt_q;
    if (ex_mis && !exc_req && (mis_cnt_q != 32'hFFFF_FFFF)) begin
      mis_cnt_d = mis_cnt_q + 32'd1;
    end else begin
      mis_cnt_d = mis_cnt_q;
    end
  end

  // Mispredict counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mis_cnt_q <= 32'd0;
    end else begin
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign mispredict_cnt = mis_cnt_q;

endmodule
